// File: rtl/str2num.sv
// rtl/str2num.sv - ASCII token parser producing a 32-bit unsigned number
module str2num #(
    parameter logic [7:0] TERM_A = 8'h0D,
    parameter logic [7:0] TERM_B = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char,
    output logic        char_ready,
    output logic        num_valid,
    input  logic        num_ready,
    output logic [31:0] num,
    output logic        err,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ERR   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_D = 8'h44;
    localparam logic [7:0] CH_H = 8'h48;

    state_t      state, state_n;
    logic [4:0]  base, base_n;
    logic [31:0] acc, acc_n;
    logic [5:0]  cnt, cnt_n;
    logic        ovf_s, ovf_s_n;
    logic [31:0] num_n;
    logic        err_n, ovf_n, num_valid_n;

    logic        accept;
    logic        is_term;
    logic        is_dec;
    logic        is_hexalpha;
    logic [3:0]  dig_val;
    logic        dig_valid;
    logic [36:0] exact;

    // The block only stalls the character stream while a result is pending.
    always_comb begin
        char_ready = (state != S_DONE);
    end

    // Character classification and the exact next accumulator value.
    always_comb begin
        accept      = char_valid && char_ready;
        is_term     = (char == TERM_A) || (char == TERM_B);
        is_dec      = (char >= 8'h30) && (char <= 8'h39);
        is_hexalpha = (char >= 8'h41) && (char <= 8'h46);
        dig_val     = 4'd0;
        if (is_dec) begin
            dig_val = 4'(char - 8'h30);
        end else if (is_hexalpha) begin
            dig_val = 4'(char - 8'h37);
        end
        dig_valid = (is_dec || is_hexalpha) && ({1'b0, dig_val} < base);
        // acc*16+15 < 2^37, so 37 bits hold the product exactly.
        exact = 37'(acc) * 37'(base) + 37'(dig_val);
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n     = state;
        base_n      = base;
        acc_n       = acc;
        cnt_n       = cnt;
        ovf_s_n     = ovf_s;
        num_n       = num;
        err_n       = err;
        ovf_n       = ovf;
        num_valid_n = num_valid;
        case (state)
            S_IDLE: begin
                if (accept && !is_term) begin
                    if (char == CH_B || char == CH_D || char == CH_H) begin
                        base_n  = (char == CH_B) ? 5'd2 : (char == CH_D) ? 5'd10 : 5'd16;
                        acc_n   = 32'd0;
                        cnt_n   = 6'd0;
                        state_n = S_ACCUM;
                    end else if (is_dec) begin
                        base_n  = 5'd10;
                        acc_n   = {28'd0, dig_val};
                        cnt_n   = 6'd1;
                        state_n = S_ACCUM;
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (is_term) begin
                        state_n     = S_DONE;
                        num_valid_n = 1'b1;
                        if (cnt == 6'd0) begin
                            num_n = 32'd0;
                            err_n = 1'b1;
                            ovf_n = 1'b0;
                        end else begin
                            num_n = acc;
                            err_n = 1'b0;
                            ovf_n = ovf_s;
                        end
                    end else if (dig_valid) begin
                        acc_n   = exact[31:0];
                        cnt_n   = (cnt == 6'd63) ? cnt : cnt + 6'd1;
                        ovf_s_n = ovf_s | (|exact[36:32]);
                    end else begin
                        state_n = S_ERR;
                    end
                end
            end
            S_ERR: begin
                if (accept && is_term) begin
                    state_n     = S_DONE;
                    num_valid_n = 1'b1;
                    num_n       = 32'd0;
                    err_n       = 1'b1;
                    ovf_n       = 1'b0;
                end
            end
            S_DONE: begin
                if (num_ready) begin
                    state_n     = S_IDLE;
                    num_valid_n = 1'b0;
                    acc_n       = 32'd0;
                    cnt_n       = 6'd0;
                    ovf_s_n     = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State, accumulator and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base      <= 5'd10;
            acc       <= 32'd0;
            cnt       <= 6'd0;
            ovf_s     <= 1'b0;
            num       <= 32'd0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            num_valid <= 1'b0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            ovf_s     <= ovf_s_n;
            num       <= num_n;
            err       <= err_n;
            ovf       <= ovf_n;
            num_valid <= num_valid_n;
        end
    end

endmodule

// File: tb/tb_str2num.sv
// tb/tb_str2num.sv - self-checking bench for str2num
module tb_str2num;

    logic        clk;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char;
    logic        char_ready;
    logic        num_valid;
    logic        num_ready;
    logic [31:0] num;
    logic        err;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rnd_mode = 0;

    logic [33:0] rq[$];
    int          rt[$];

    str2num dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char       (char),
        .char_ready (char_ready),
        .num_valid  (num_valid),
        .num_ready  (num_ready),
        .num        (num),
        .err        (err),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every consumed result with the edge number it was taken on.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && num_valid && num_ready) begin
            rq.push_back({num, err, ovf});
            rt.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // '~' stands for carriage return in the directed strings.
    function automatic void str2q(input string s, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < s.len(); i++) begin
            q.push_back((s[i] == "~") ? 8'h0D : s[i]);
        end
    endfunction

    function automatic bit is_term(input logic [7:0] c);
        return (c == 8'h0D) || (c == 8'h20);
    endfunction

    function automatic int digval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Whole-token reference: {num, err, ovf} for one token with leading whitespace.
    function automatic logic [33:0] model(input logic [7:0] q[$]);
        int          i = 0;
        int          base;
        int          start;
        int          d;
        longint      v = 0;
        bit          o = 0;
        logic [7:0]  body[$];
        logic [31:0] lo;
        while (i < q.size() && is_term(q[i])) i++;
        while (i < q.size() && !is_term(q[i])) begin
            body.push_back(q[i]);
            i++;
        end
        if (body.size() == 0) return {32'd0, 1'b1, 1'b0};
        if (body[0] == "B")      begin base = 2;  start = 1; end
        else if (body[0] == "D") begin base = 10; start = 1; end
        else if (body[0] == "H") begin base = 16; start = 1; end
        else if (body[0] >= "0" && body[0] <= "9") begin base = 10; start = 0; end
        else return {32'd0, 1'b1, 1'b0};
        if (start >= body.size()) return {32'd0, 1'b1, 1'b0};
        for (int k = start; k < body.size(); k++) begin
            d = digval(body[k]);
            if (d < 0 || d >= base) return {32'd0, 1'b1, 1'b0};
            v = v * base + d;
            if (v >= 64'h1_0000_0000) begin
                o = 1;
                v = v % 64'h1_0000_0000;
            end
        end
        lo = v[31:0];
        return {lo, 1'b0, o};
    endfunction

    task automatic send(input logic [7:0] q[$]);
        int guard;
        for (int i = 0; i < q.size(); i++) begin
            if (rnd_mode) begin
                int gap = $urandom_range(0, 2);
                char_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    num_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            char_valid = 1'b1;
            char       = q[i];
            guard      = 0;
            while (!char_ready && guard < 1000) begin
                if (rnd_mode) num_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) check("send_timeout", 64'(guard), 64'd0);
            @(posedge clk);
            @(negedge clk);
            if (rnd_mode) num_ready = 1'($urandom_range(0, 1));
        end
        char_valid = 1'b0;
    endtask

    task automatic run_tok(input string tag, input string s, input logic [31:0] en,
                           input logic ee, input logic eo);
        logic [7:0] q[$];
        int         guard = 0;
        str2q(s, q);
        rq.delete();
        num_ready = 1'b1;
        send(q);
        while (rq.size() == 0 && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, "_got"}, 64'(rq.size()), 64'd1);
        if (rq.size() > 0) begin
            check({tag, "_num"}, 64'(rq[0][33:2]), 64'(en));
            check({tag, "_err"}, 64'(rq[0][1]), 64'(ee));
            check({tag, "_ovf"}, 64'(rq[0][0]), 64'(eo));
            check({tag, "_model"}, 64'(rq[0]), 64'(model(q)));
        end
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [33:0] exp_q[$];
        int          guard;
        string       pool = "GaZ.F9x";

        rst = 1'b1; char_valid = 1'b0; char = 8'h00; num_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_num_valid", 64'(num_valid), 64'd0);
        check("rst_num", 64'(num), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_char_ready", 64'(char_ready), 64'd1);

        // "123\r": result visible the cycle after CR is accepted.
        str2q("123", q);
        send(q);
        check("t123_pre_valid", 64'(num_valid), 64'd0);
        str2q("~", q);
        send(q);
        check("t123_valid", 64'(num_valid), 64'd1);
        check("t123_num", 64'(num), 64'd123);
        check("t123_err", 64'(err), 64'd0);
        check("t123_ovf", 64'(ovf), 64'd0);
        check("t123_char_ready", 64'(char_ready), 64'd0);
        rq.delete();
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
        check("t123_consumed", 64'(rq.size()), 64'd1);
        check("t123_valid_low", 64'(num_valid), 64'd0);

        // Back-to-back tokens with the consumer always ready.
        rq.delete(); rt.delete();
        num_ready = 1'b1;
        str2q("H1F B101~D0042 ", q);
        send(q);
        guard = 0;
        while (rq.size() < 3 && guard < 50) begin tick(); guard++; end
        check("b2b_count", 64'(rq.size()), 64'd3);
        if (rq.size() == 3) begin
            check("b2b_r0", 64'(rq[0]), {30'd0, 32'h1F, 2'b00});
            check("b2b_r1", 64'(rq[1]), {30'd0, 32'd5, 2'b00});
            check("b2b_r2", 64'(rq[2]), {30'd0, 32'd42, 2'b00});
            check("b2b_gap1", 64'(rt[1] - rt[0]), 64'd6);
            check("b2b_gap2", 64'(rt[2] - rt[1]), 64'd7);
        end

        run_tok("hmax", "HFFFFFFFF~", 32'hFFFFFFFF, 1'b0, 1'b0);
        run_tok("hovf", "H100000000~", 32'd0, 1'b0, 1'b1);
        run_tok("dovf", "4294967296 ", 32'd0, 1'b0, 1'b1);

        // Bad binary digit reports nothing until the terminator.
        num_ready = 1'b1;
        str2q("B102", q);
        send(q);
        tick();
        check("b102_pre_valid", 64'(num_valid), 64'd0);
        run_tok("b102", "~", 32'd0, 1'b1, 1'b0);
        run_tok("lower", "h12 ", 32'd0, 1'b1, 1'b0);
        run_tok("noDig", "H~", 32'd0, 1'b1, 1'b0);

        // Backpressure: result held steady while the consumer stalls.
        rq.delete();
        num_ready = 1'b0;
        str2q("  7~", q);
        send(q);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(num_valid), 64'd1);
            check("bp_num", 64'(num), 64'd7);
            check("bp_flags", 64'({err, ovf}), 64'd0);
            check("bp_char_ready", 64'(char_ready), 64'd0);
            tick();
        end
        num_ready = 1'b1;
        tick();
        num_ready = 1'b0;
        check("bp_once", 64'(rq.size()), 64'd1);
        check("bp_valid_low", 64'(num_valid), 64'd0);
        tick();
        check("bp_still_once", 64'(rq.size()), 64'd1);

        // Reset mid-token drops the partial value.
        str2q("D12", q);
        send(q);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_outs", 64'({num_valid, num, err, ovf}), 64'd0);
        check("mrst_char_ready", 64'(char_ready), 64'd1);
        run_tok("mrst7", "7~", 32'd7, 1'b0, 1'b0);

        // Random tokens with input gaps and random consumer stalls.
        rq.delete();
        rnd_mode = 1;
        for (int t = 0; t < 40; t++) begin
            int         f = $urandom_range(0, 5);
            int         base;
            int         nd;
            logic [7:0] c;
            q = {};
            for (int l = $urandom_range(0, 2); l > 0; l--)
                q.push_back($urandom_range(0, 1) ? 8'h20 : 8'h0D);
            case (f)
                0: begin q.push_back("B"); base = 2;  end
                1: begin q.push_back("D"); base = 10; end
                2: begin q.push_back("H"); base = 16; end
                5: begin q.push_back("h"); base = 16; end
                default: base = 10;
            endcase
            nd = $urandom_range(0, 12);
            if ((f == 3 || f == 4) && nd == 0) nd = 1;
            for (int k = 0; k < nd; k++) begin
                if ($urandom_range(0, 19) == 0) begin
                    c = pool[$urandom_range(0, pool.len() - 1)];
                end else begin
                    int d = $urandom_range(0, base - 1);
                    c = (d < 10) ? 8'(48 + d) : 8'(55 + d);
                end
                q.push_back(c);
            end
            q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h20);
            exp_q.push_back(model(q));
            send(q);
        end
        rnd_mode = 0;
        num_ready = 1'b1;
        guard = 0;
        while (rq.size() < exp_q.size() && guard < 200) begin tick(); guard++; end
        check("rnd_count", 64'(rq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rq.size(); i++) begin
            check($sformatf("rnd_%0d", i), 64'(rq[i]), 64'(exp_q[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
